// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - 32-cycle shift-and-add multiply sequencer for the EX stage
module mul_sequencer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [2:0]  ALUCtrl_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic [4:0]  rd_addr_o
);

    localparam logic [2:0] ALU_MUL  = 3'b101;
    localparam logic [4:0] LAST_CNT = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [63:0] mcand;
    logic [63:0] acc;
    logic [31:0] mplier;
    logic [4:0]  count;
    logic [4:0]  rd_q;
    logic        accept;
    logic        run_step;

    // The upper half of the product is accumulated at full width but never exported.
    logic        acc_hi_unused;
    assign acc_hi_unused = ^acc[63:32];

    // A MUL is taken only from IDLE or DONE, and never while flushing or in reset.
    always_comb begin
        accept = 1'b0;
        if (!rst_i && !flush_i && valid_i && (ALUCtrl_i == ALU_MUL) &&
            ((state == S_IDLE) || (state == S_DONE))) begin
            accept = 1'b1;
        end
    end

    // One shift-and-add step per RUN cycle; a flush freezes the datapath in place.
    assign run_step = (state == S_RUN) && !flush_i;

    // State register; reset wins over everything else.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush overrides every transition, unused encoding recovers to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (count == LAST_CNT) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = accept ? S_RUN : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (flush_i) begin
            state_next = S_IDLE;
        end
    end

    // Operand load on acceptance, then iterate; registers hold outside RUN.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            rd_q   <= '0;
        end else if (accept) begin
            mcand  <= {32'd0, rs1_data_i};
            mplier <= rs2_data_i;
            acc    <= '0;
            count  <= '0;
            rd_q   <= rd_addr_i;
        end else if (run_step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 5'd1;
        end
    end

    // Pipeline handshake outputs; flush and reset silence stall and done in their cycle.
    always_comb begin
        stall_o = 1'b0;
        done_o  = 1'b0;
        busy_o  = (state != S_IDLE);
        if (!rst_i && !flush_i) begin
            stall_o = (state == S_RUN) || accept;
            done_o  = (state == S_DONE);
        end
    end

    assign result_o  = acc[31:0];
    assign rd_addr_o = rd_q;

endmodule
